// File: rtl/xpb_reduce_sequencer.sv
// xpb_reduce_sequencer
// Walks the NUM_SEG segments of a product's overflow bits one per cycle,
// addresses the shared xpb table bank with each segment, and accumulates the
// returned reduction constants into one wide sum for the final adder tree.
//
// Build option: define XPB_LUT_REG_EN to register the table output before
// the accumulator (adds one DRAIN cycle; same final sum).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an upper-bit word; in_ready high
// RUN   | issuing one table lookup per cycle, segment 0 first
// DRAIN | (registered table mode) folding in the last registered value
// DONE  | out_sum presented with out_valid until out_ready

module xpb_reduce_sequencer #(
    parameter int XPB_W   = 1024,
    parameter int SEG_W   = 5,
    parameter int NUM_SEG = 8,
    parameter int SEL_W   = 3,
    parameter int ACC_W   = 1032
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SEG*SEG_W-1:0] in_data,
    output logic [SEL_W-1:0]         lut_sel,
    output logic [SEG_W-1:0]         lut_data,
    input  logic [XPB_W-1:0]         lut_value,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_sum,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [SEL_W-1:0]         seg_idx;
    logic [NUM_SEG*SEG_W-1:0] word_q;
    logic [ACC_W-1:0]         acc;
    logic [ACC_W-1:0]         acc_next;
    logic [ACC_W-1:0]         sum_q;
    logic [SEG_W-1:0]         seg_cur;
    logic [XPB_W-1:0]         add_val;
    logic                     last_seg;

`ifdef XPB_LUT_REG_EN
    logic [XPB_W-1:0]         lut_q;
    // accumulator lags the lookup by one cycle; lut_q is zeroed at accept so
    // the first RUN cycle adds nothing
    assign add_val = lut_q;
`else
    assign add_val = lut_value;
`endif

    assign last_seg = (seg_idx == SEL_W'(NUM_SEG - 1));
    assign acc_next = acc + ACC_W'(add_val);
    assign out_sum  = sum_q;

    // select the segment addressed by seg_idx from the latched word
    always_comb begin
        seg_cur = '0;
        for (int k = 0; k < NUM_SEG; k++) begin
            if (seg_idx == SEL_W'(k)) begin
                seg_cur = word_q[k*SEG_W +: SEG_W];
            end
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state and handshake/lookup outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        lut_sel   = '0;
        lut_data  = '0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                lut_sel  = seg_idx;
                lut_data = seg_cur;
                if (last_seg) begin
`ifdef XPB_LUT_REG_EN
                    state_nxt = S_DRAIN;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
            S_DRAIN: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // word latch, segment counter, accumulator and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            seg_idx <= '0;
            acc     <= '0;
            sum_q   <= '0;
`ifdef XPB_LUT_REG_EN
            lut_q   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        word_q  <= in_data;
                        seg_idx <= '0;
                        acc     <= '0;
`ifdef XPB_LUT_REG_EN
                        lut_q   <= '0;
`endif
                    end
                end
                S_RUN: begin
                    acc     <= acc_next;
                    seg_idx <= seg_idx + SEL_W'(1);
`ifdef XPB_LUT_REG_EN
                    lut_q   <= lut_value;
`else
                    if (last_seg) begin
                        sum_q <= acc_next;
                    end
`endif
                end
                S_DRAIN: begin
                    acc   <= acc_next;
                    sum_q <= acc_next;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xpb_reduce_sequencer.sv
// Directed bench for xpb_reduce_sequencer: a small table model answers the
// lookups as (lut_sel+1)*lut_data, or all-ones to stand in for full tables.

module tb_xpb_reduce_sequencer;

    localparam int XPB_W   = 1024;
    localparam int SEG_W   = 5;
    localparam int NUM_SEG = 8;
    localparam int SEL_W   = 3;
    localparam int ACC_W   = 1032;
`ifdef XPB_LUT_REG_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 9;
`endif

    logic                     clk;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_SEG*SEG_W-1:0] in_data;
    logic [SEL_W-1:0]         lut_sel;
    logic [SEG_W-1:0]         lut_data;
    logic [XPB_W-1:0]         lut_value;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_W-1:0]         out_sum;
    logic                     busy;

    logic                     tbl_mode;
    logic [31:0]              prod;
    int                       total;
    int                       passed;
    int                       fails;

    localparam logic [39:0] W_ZERO = 40'd0;
    localparam logic [39:0] W_ONES = {8{5'h1F}};
    localparam logic [39:0] W_RAMP = {5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};

    xpb_reduce_sequencer #(
        .XPB_W(XPB_W), .SEG_W(SEG_W), .NUM_SEG(NUM_SEG), .SEL_W(SEL_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .lut_sel(lut_sel), .lut_data(lut_data), .lut_value(lut_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // table bank model
    always_comb begin
        prod      = ({29'd0, lut_sel} + 32'd1) * {27'd0, lut_data};
        lut_value = XPB_W'(prod);
        if (tbl_mode) begin
            lut_value = '1;
        end
    end

    task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [39:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("accepted_busy", busy, 1);
        chk("accepted_in_ready", in_ready, 0);
    endtask

    // called in the first RUN cycle; returns in the first DONE cycle
    task automatic wait_out(input string tag, input bit chk_sel);
        int n;
        n = 1;
        while (out_valid !== 1'b1 && n < 100) begin
            if (chk_sel && n <= NUM_SEG) begin
                chk("lut_sel_step", lut_sel, n - 1);
                chk("lut_data_step", lut_data, n);
            end
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, LAT);
    endtask

    task automatic release_out(input logic [ACC_W-1:0] exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_out_sum_hold", out_sum, exp);
    endtask

    initial begin
        logic [ACC_W-1:0] big_exp;
        bit               seen_valid;
        total     = 0;
        passed    = 0;
        fails     = 0;
        tbl_mode  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lut_sel", lut_sel, 0);
        chk("rst_lut_data", lut_data, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // zero word
        send(W_ZERO);
        wait_out("zero", 1'b0);
        chk("zero_sum", out_sum, 0);
        release_out(0);

        // all segments max: 31*(1+..+8)
        send(W_ONES);
        wait_out("ones", 1'b0);
        chk("ones_sum", out_sum, 1116);
        release_out(1116);

        // ramp with lookup sequencing check: sum of squares 1..8
        send(W_RAMP);
        wait_out("ramp", 1'b1);
        chk("ramp_sum", out_sum, 204);
        release_out(204);

        // backpressure in DONE, with a new word offered during DONE
        send(W_ONES);
        wait_out("bp", 1'b0);
        in_valid = 1'b1;
        in_data  = W_RAMP;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_sum", out_sum, 1116);
            chk("bp_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_hs_idle", busy, 0);
        chk("bp_hs_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_accepted", busy, 1);
        wait_out("bp_next", 1'b0);
        chk("bp_next_sum", out_sum, 204);
        release_out(204);

        // reset in the 4th RUN cycle
        send(W_RAMP);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_lut_sel", lut_sel, 0);
        seen_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (out_valid === 1'b1) seen_valid = 1'b1;
            @(posedge clk); #1;
        end
        chk("midrst_no_out_valid", seen_valid, 0);
        send(W_ONES);
        wait_out("after_rst", 1'b0);
        chk("after_rst_sum", out_sum, 1116);
        release_out(1116);

        // full-width tables: 8 * (2^1024 - 1) = 2^1027 - 8
        tbl_mode = 1'b1;
        big_exp  = (ACC_W'(1) << 1027) - ACC_W'(8);
        send(W_ONES);
        wait_out("max", 1'b0);
        chk("max_sum", out_sum, big_exp);
        release_out(big_exp);
        tbl_mode = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
